// File: rtl/blk_mem_rd_stream_if.sv
// Bundles the RAM read port and the outbound valid/ready stream of blk_mem_rd_stream.
// master = the sequencer, slave = the RAM plus the stream consumer.
interface blk_mem_rd_stream_if #(
    parameter int BIT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [BIT_WIDTH-1:0]  mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIT_WIDTH-1:0]  out_data;
    logic                  out_last;

    modport master (
        output mem_rd_en, mem_addr_out, out_valid, out_data, out_last,
        input  mem_rd_data, out_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr_out, out_valid, out_data, out_last,
        output mem_rd_data, out_ready
    );
endinterface

// File: rtl/blk_mem_rd_stream.sv
// Block-RAM read sequencer: walks a wrapping address range with one-cycle-latency reads
// and re-emits the words as a valid/ready stream through a 2-entry buffer.
module blk_mem_rd_stream #(
    parameter int BIT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    blk_mem_rd_stream_if.master   bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   len_q, issued;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight, inflight_last;
    logic [1:0]            count;
    logic [BIT_WIDTH-1:0]  buf0, buf1;
    logic                  last0, last1;
    logic                  pop, issue, issue_last, accept;
    logic [2:0]            occ;

    // occ = slots that will be held after this edge if nothing new is issued
    always_comb begin
        pop        = (count != 2'd0) && bus.out_ready;
        occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        accept     = (state == IDLE) && start && !done;
        issue      = (state == RUN) && (occ < 3'd2);
        issue_last = (issued == len_q - (ADDR_WIDTH+1)'(1));
        state_nx   = state;
        case (state)
            IDLE:    if (accept) state_nx = (length == '0) ? DRAIN : RUN;
            RUN:     if (issue && issue_last) state_nx = DRAIN;
            DRAIN:   if (occ == 3'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            done          <= 1'b0;
            len_q         <= '0;
            issued        <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nx;
            done          <= (state == DRAIN) && (occ == 3'd0);
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            if (accept) begin
                addr_q <= base_addr;
                len_q  <= (length > DEPTH) ? DEPTH : length;
                issued <= '0;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                issued <= issued + (ADDR_WIDTH+1)'(1);
            end
        end
    end

    // Head stays in buf0; a landing read goes to the first free slot after any pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            buf0  <= '0;
            buf1  <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf0  <= bus.mem_rd_data;
                        last0 <= inflight_last;
                    end else begin
                        buf1  <= bus.mem_rd_data;
                        last1 <= inflight_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf0  <= buf1;
                    last0 <= last1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        buf0  <= bus.mem_rd_data;
                        last0 <= inflight_last;
                    end else begin
                        buf0  <= buf1;
                        last0 <= last1;
                        buf1  <= bus.mem_rd_data;
                        last1 <= inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign bus.mem_rd_en    = issue;
    assign bus.mem_addr_out = addr_q;
    assign bus.out_valid    = (count != 2'd0);
    assign bus.out_data     = buf0;
    assign bus.out_last     = last0;
endmodule

// File: doc/blk_mem_rd_stream.md
# blk_mem_rd_stream

Read-side sequencer that sits directly downstream of the block RAM. On a start command it walks a contiguous, wrapping address range, issues one-cycle-latency reads, and re-emits the returned words as a valid/ready stream with a last-beat marker. A 2-entry output buffer absorbs the RAM read latency so consumer back-pressure never drops or duplicates data.

## Interface
- BIT_WIDTH, 16, data word width; must match the RAM.
- ADDR_WIDTH, 4, RAM address width; depth = 2^ADDR_WIDTH.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a burst; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of the burst; sampled with start.
- length  in  ADDR_WIDTH+1  beat count, 0..2^ADDR_WIDTH; sampled with start.
- mem_rd_en  out  1  read strobe, high in every cycle an address is issued.
- mem_addr_out  out  ADDR_WIDTH  read address to the RAM.
- mem_rd_data  in  BIT_WIDTH  RAM read data, valid exactly one cycle after the issuing cycle.
- out_valid  out  1  stream data valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  BIT_WIDTH  stream data.
- out_last  out  1  marks the final beat of the burst.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 latches base_addr and length.
  - If length>2^ADDR_WIDTH, the latched length saturates to 2^ADDR_WIDTH.
  - length=0 goes to DRAIN with no beats issued.
  - Otherwise goes to RUN.
- RUN:
  - Issues one read per cycle when the credit rule allows.
  - The address starts at base_addr and increments modulo 2^ADDR_WIDTH; it wraps from 2^ADDR_WIDTH-1 to 0.
  - After the length-th issue, moves to DRAIN.
- DRAIN:
  - Waits until the in-flight read has landed and the buffer is empty, with the final beat handshaken.
  - Then pulses done and returns to IDLE.
- Credit rule: issue only if buffer_count + inflight - pop < 2.
  - inflight is 1 if a read was issued last cycle, else 0.
  - pop = out_valid & out_ready.
  - With out_ready held high, throughput is 1 beat/cycle.
- Capture: in the cycle after an issue, mem_rd_data is written to the buffer tail.
  - The capture is unconditional; the credit rule guarantees space.
- out_data is the buffer head (registered storage); out_valid = buffer non-empty.
- out_last is high on the beat whose sequence index = length-1.
- Simultaneous push and pop in one cycle: the count is unchanged and ordering is preserved.
- start while busy is ignored.
- start in the same cycle that done pulses is ignored; start is accepted from the next cycle.
- Once out_valid is asserted, out_data and out_last hold stable until the beat is handshaken.
- Reset (any time, including mid-burst):
  - state returns to IDLE.
  - The buffer and in-flight data are discarded.
  - All outputs go to 0: mem_rd_en, mem_addr_out, out_valid, out_data, out_last, busy, done.

## Timing
- start accepted at cycle T:
  - busy=1 from T+1.
  - First mem_rd_en/mem_addr_out=base_addr in T+1.
  - Data captured at the end of T+2; out_valid=1 in T+3.
- With out_ready=1 throughout, an N-beat burst:
  - Beats appear in T+3 … T+N+2; out_last is in T+N+2.
  - done=1 and busy=0 in T+N+3.
- length=0: busy=1 in T+1 only, done in T+2, no mem_rd_en, no beats.
- Back-pressure: after out_ready drops, at most one further read issues and lands. Issue stalls until credit frees.
- mem_rd_en is never high in IDLE or DRAIN.

## Test plan
- RAM preloaded mem[i]=0x1000+i, base_addr=2, length=5, out_ready=1 -> beats 0x1002..0x1006 in T+3..T+7, out_last only on 0x1006, done in T+8.
- base_addr=14, length=4, ADDR_WIDTH=4 -> addresses 14,15,0,1; data 0x100E,0x100F,0x1000,0x1001.
- length=16, out_ready toggling 1,0,0,1,… -> all 16 words once, in order, no loss or duplicates; out_data stable while stalled; never more than 2 buffered plus 1 in flight.
- length=0 -> done in T+2, out_valid never asserted; length=20 -> exactly 16 beats.
- rst_n low after the third beat of an 8-beat burst -> all outputs 0 immediately; a new start after release gives a clean burst from its own base_addr.
- start pulsed while busy and in the done cycle -> ignored; no second burst.
